// File: rtl/sdcard_dma.sv
// Sector DMA engine for the memory-mapped SPI SD card block: sequences card
// commands and moves whole 512-byte sectors between the card cache and memory.
module sdcard_dma #(
  parameter logic [23:0] TIMEOUT = 24'hffffff
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic [15:0] sd_a,
  output logic [31:0] sd_d,
  output logic        sd_we,
  input  logic [31:0] sd_spo,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_rd,
  output logic        mem_we,
  input  logic [31:0] mem_spo,
  input  logic        mem_ready,
  output logic [2:0]  state_dbg
);
  // Memory handshake: mem_rd/mem_we are held with stable mem_a/mem_d until a
  // cycle where mem_ready=1 (that same cycle counts, including the first one);
  // the request drops on the following cycle. sd_we is a one-cycle strobe.
  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_FILL, S_SETADDR, S_CMD, S_WAIT, S_DRAIN, S_NEXT
  } state_t;

  localparam logic [15:0] SD_STATUS = 16'h2010;
  localparam logic [15:0] SD_ADDR   = 16'h1000;
  localparam logic [15:0] SD_READ   = 16'h1004;
  localparam logic [15:0] SD_WRITE  = 16'h1008;
  localparam logic [31:0] SD_CMD_GO = 32'h01000000;
  localparam logic [6:0]  LAST_WORD = 7'd127;

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  state_t      state;
  logic [31:0] sector, memaddr;
  logic [15:0] count;
  logic        dir, irq_en, done, error, filled;
  logic [6:0]  idx;
  logic [1:0]  phase;
  logic [23:0] timer;

  logic        ctrl_wr, start_req, abort_req, busy, sd_ready, poll_expired;
  logic [31:0] word_off;

  assign ctrl_wr      = we && (a == 4'hc);
  assign start_req    = ctrl_wr && d[0];
  assign abort_req    = ctrl_wr && d[3];
  assign busy         = (state != S_IDLE);
  assign sd_ready     = sd_spo[24];
  assign poll_expired = (timer >= TIMEOUT - 24'd1);
  assign word_off     = {23'b0, idx, 2'b00};
  assign irq          = (done | error) & irq_en;
  assign state_dbg    = state;

  always_comb begin
    spo = '0;
    case (a)
      4'h0:    spo = sector;
      4'h4:    spo = memaddr;
      4'h8:    spo = {16'h0, count};
      4'hc:    spo = {count, 11'b0, busy, done, error, irq_en, dir};
      default: spo = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sector <= '0; memaddr <= '0; count <= '0;
      dir <= 1'b0; irq_en <= 1'b0; done <= 1'b0; error <= 1'b0; filled <= 1'b0;
      idx <= '0; phase <= '0; timer <= '0;
      sd_a <= SD_STATUS; sd_d <= '0; sd_we <= 1'b0;
      mem_a <= '0; mem_d <= '0; mem_rd <= 1'b0; mem_we <= 1'b0;
    end else begin
      if (we && !busy) begin
        case (a)
          4'h0: sector  <= {d[31:9], 9'b0};
          4'h4: memaddr <= {d[31:2], 2'b0};
          4'h8: count   <= d[15:0];
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en <= d[2];
        if (!busy) dir <= d[1];
        if (d[4]) begin
          done  <= 1'b0;
          error <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (start_req) begin
            done  <= (count == 16'd0);
            error <= 1'b0;
            if (count != 16'd0) begin
              state  <= S_POLL;
              timer  <= '0;
              filled <= 1'b0;
            end
          end
        end
        S_POLL: begin
          if (sd_ready) begin
            timer <= '0;
            if (dir && !filled) begin
              state  <= S_FILL;
              idx    <= '0;
              phase  <= 2'd0;
              mem_rd <= 1'b1;
              mem_a  <= memaddr;
            end else begin
              state <= S_SETADDR;
              sd_a  <= SD_ADDR;
              sd_d  <= swap32(sector);
              sd_we <= 1'b1;
            end
          end else if (poll_expired) begin
            state <= S_IDLE;
            error <= 1'b1;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        S_FILL: begin
          // Three beats per word: memory read, cache write, issue next read.
          case (phase)
            2'd0: if (mem_ready) begin
              mem_rd <= 1'b0;
              sd_d   <= mem_spo;
              sd_a   <= {7'b0, idx, 2'b00};
              sd_we  <= 1'b1;
              phase  <= 2'd1;
            end
            2'd1: begin
              sd_we <= 1'b0;
              if (idx == LAST_WORD) begin
                state  <= S_POLL;
                filled <= 1'b1;
                sd_a   <= SD_STATUS;
                timer  <= '0;
              end else begin
                idx   <= idx + 7'd1;
                phase <= 2'd2;
              end
            end
            default: begin
              mem_rd <= 1'b1;
              mem_a  <= memaddr + word_off;
              phase  <= 2'd0;
            end
          endcase
        end
        S_SETADDR: begin
          sd_we <= 1'b0;
          state <= S_CMD;
        end
        S_CMD: begin
          sd_a  <= dir ? SD_WRITE : SD_READ;
          sd_d  <= SD_CMD_GO;
          sd_we <= 1'b1;
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // The command strobe cycle is not a status read, so it is skipped.
          if (sd_we) begin
            sd_we <= 1'b0;
            sd_a  <= SD_STATUS;
          end else if (sd_ready) begin
            if (dir) begin
              state <= S_NEXT;
            end else begin
              state <= S_DRAIN;
              idx   <= '0;
              phase <= 2'd0;
              sd_a  <= 16'h0000;
            end
          end else if (poll_expired) begin
            state <= S_IDLE;
            error <= 1'b1;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        S_DRAIN: begin
          if (phase == 2'd0) begin
            mem_we <= 1'b1;
            mem_a  <= memaddr + word_off;
            mem_d  <= sd_spo;
            phase  <= 2'd1;
          end else if (mem_ready) begin
            mem_we <= 1'b0;
            phase  <= 2'd0;
            if (idx == LAST_WORD) begin
              state <= S_NEXT;
              sd_a  <= SD_STATUS;
            end else begin
              idx  <= idx + 7'd1;
              sd_a <= {7'b0, idx + 7'd1, 2'b00};
            end
          end
        end
        S_NEXT: begin
          sector  <= sector + 32'd512;
          memaddr <= memaddr + 32'd512;
          count   <= count - 16'd1;
          filled  <= 1'b0;
          timer   <= '0;
          if (count == 16'd1) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state <= S_POLL;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (abort_req) begin
        state  <= S_IDLE;
        sd_we  <= 1'b0;
        sd_a   <= SD_STATUS;
        mem_rd <= 1'b0;
        mem_we <= 1'b0;
        error  <= 1'b1;
      end
    end
  end
endmodule
